// File: rtl/gpr_pkg.sv
// Shared constants and types for the gpr_mp register file.
// Default geometry matches the legacy 10x10-bit, 3-read-port register file.
package gpr_pkg;

    localparam int GPR_WIDTH = 10;
    localparam int GPR_DEPTH = 10;
    localparam int GPR_NRD   = 3;
    localparam int GPR_AW    = $clog2(GPR_DEPTH);

    typedef logic [GPR_AW-1:0]    gpr_addr_t;
    typedef logic [GPR_WIDTH-1:0] gpr_data_t;

endpackage

// File: rtl/gpr_rdport.sv
// One registered read port of gpr_mp.
// Applies write-first bypass and range checking. Outputs reflect the
// register file state after the current clock edge's write/reserve update.
module gpr_rdport
    import gpr_pkg::*;
#(
    parameter int WIDTH = GPR_WIDTH,
    parameter int DEPTH = GPR_DEPTH,
    parameter int AW    = GPR_AW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en_i,
    input  logic [AW-1:0]          rd_addr_i,
    input  logic [DEPTH*WIDTH-1:0] mem_flat_i,
    input  logic [DEPTH-1:0]       busy_i,
    input  logic                   wr_en_i,
    input  logic [AW-1:0]          wr_addr_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   res_en_i,
    input  logic [AW-1:0]          res_addr_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   rd_valid_o,
    output logic                   rd_busy_o,
    output logic                   rd_err_o
);

    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

    logic             in_range;
    logic [AW-1:0]    sel;
    logic             wr_hit;
    logic             res_hit;
    logic [WIDTH-1:0] data_d, data_q;
    logic             busy_d, busy_q;
    logic             valid_q;

    // Select the addressed word, then let a same-cycle write/reserve override it.
    always_comb begin
        in_range = ({1'b0, rd_addr_i} < DEPTH_L);
        sel      = in_range ? rd_addr_i : '0;
        wr_hit   = wr_en_i  && (wr_addr_i  == rd_addr_i);
        res_hit  = res_en_i && (res_addr_i == rd_addr_i);
        data_d   = '0;
        busy_d   = 1'b0;
        if (in_range) begin
            data_d = wr_hit ? wr_data_i : mem_flat_i[int'(sel)*WIDTH +: WIDTH];
            // A new producer reserving in the same cycle outranks the writeback clear.
            if (res_hit)
                busy_d = 1'b1;
            else if (wr_hit)
                busy_d = 1'b0;
            else
                busy_d = busy_i[sel];
        end
        rd_err_o = rd_en_i && !in_range;
    end

    // Capture read result; data and busy hold when the port is idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_en_i;
            if (rd_en_i) begin
                data_q <= data_d;
                busy_q <= busy_d;
            end
        end
    end

    assign rd_data_o  = data_q;
    assign rd_valid_o = valid_q;
    assign rd_busy_o  = busy_q;

endmodule

// File: rtl/gpr_mp.sv
// Parametrised multi-port general-purpose register file with busy scoreboard.
// Optional macro GPR_MP_DBG_EN adds the dbg_regs flattened register view.
module gpr_mp
    import gpr_pkg::*;
#(
    parameter int WIDTH = GPR_WIDTH,
    parameter int DEPTH = GPR_DEPTH,
    parameter int NRD   = GPR_NRD,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 write,
    input  logic [AW-1:0]        inaddr,
    input  logic [WIDTH-1:0]     indata,
    input  logic                 reserve,
    input  logic [AW-1:0]        resaddr,
    input  logic [NRD-1:0]       read,
    input  logic [NRD*AW-1:0]    outaddr,
    output logic [NRD*WIDTH-1:0] outdata,
    output logic [NRD-1:0]       outvalid,
    output logic [NRD-1:0]       outbusy,
    output logic [DEPTH-1:0]     busy,
    output logic                 addr_err
`ifdef GPR_MP_DBG_EN
    ,
    output logic [DEPTH*WIDTH-1:0] dbg_regs
`endif
);

    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [DEPTH*WIDTH-1:0] mem_flat;
    logic [DEPTH-1:0]       busy_d, busy_q;
    logic                   addr_err_q;
    logic                   wr_ok, res_ok;
    logic [NRD-1:0]         rd_err;

    // Range-qualified write/reserve and next scoreboard (reserve applied last so it wins).
    always_comb begin
        wr_ok  = write   && ({1'b0, inaddr}  < DEPTH_L);
        res_ok = reserve && ({1'b0, resaddr} < DEPTH_L);
        busy_d = busy_q;
        if (wr_ok)
            busy_d[inaddr] = 1'b0;
        if (res_ok)
            busy_d[resaddr] = 1'b1;
    end

    // Flatten the storage array for the read ports and the debug view.
    always_comb begin
        mem_flat = '0;
        for (int k = 0; k < DEPTH; k++)
            mem_flat[k*WIDTH +: WIDTH] = mem_q[k];
    end

    // Storage, scoreboard and error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++)
                mem_q[k] <= '0;
            busy_q     <= '0;
            addr_err_q <= 1'b0;
        end else begin
            if (wr_ok)
                mem_q[inaddr] <= indata;
            busy_q     <= busy_d;
            addr_err_q <= (write && !wr_ok) || (reserve && !res_ok) || (|rd_err);
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        gpr_rdport #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_rdport (
            .clk        (clk),
            .rst        (rst),
            .rd_en_i    (read[i]),
            .rd_addr_i  (outaddr[i*AW +: AW]),
            .mem_flat_i (mem_flat),
            .busy_i     (busy_q),
            .wr_en_i    (write),
            .wr_addr_i  (inaddr),
            .wr_data_i  (indata),
            .res_en_i   (reserve),
            .res_addr_i (resaddr),
            .rd_data_o  (outdata[i*WIDTH +: WIDTH]),
            .rd_valid_o (outvalid[i]),
            .rd_busy_o  (outbusy[i]),
            .rd_err_o   (rd_err[i])
        );
    end

    assign busy     = busy_q;
    assign addr_err = addr_err_q;

`ifdef GPR_MP_DBG_EN
    assign dbg_regs = mem_flat;
`endif

endmodule

// File: tb/tb_gpr_mp.sv
// Self-checking bench for gpr_mp (WIDTH=10, DEPTH=10, NRD=3).
module tb_gpr_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        write;
    logic [3:0]  inaddr;
    logic [9:0]  indata;
    logic        reserve;
    logic [3:0]  resaddr;
    logic [2:0]  read;
    logic [11:0] outaddr;
    logic [29:0] outdata;
    logic [2:0]  outvalid;
    logic [2:0]  outbusy;
    logic [9:0]  busy;
    logic        addr_err;

    gpr_mp dut (
        .clk      (clk),
        .rst      (rst),
        .write    (write),
        .inaddr   (inaddr),
        .indata   (indata),
        .reserve  (reserve),
        .resaddr  (resaddr),
        .read     (read),
        .outaddr  (outaddr),
        .outdata  (outdata),
        .outvalid (outvalid),
        .outbusy  (outbusy),
        .busy     (busy),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] port;
        logic [9:0] d;
        logic       b;
    } exp_t;

    exp_t       sb[$];
    logic [9:0] m  [10];
    logic [9:0] bz;
    logic [9:0] last_d [3];
    logic       last_b [3];
    int         compared   = 0;
    int         mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 10; k++) m[k] = '0;
        bz = '0;
        for (int p = 0; p < 3; p++) begin
            last_d[p] = '0;
            last_b[p] = 1'b0;
        end
        sb.delete();
    endtask

    // One clock of stimulus: drive at negedge, predict, check 1 time unit after posedge.
    task automatic step(input logic wr, input logic [3:0] wa, input logic [9:0] wd,
                        input logic rs, input logic [3:0] ra,
                        input logic [2:0] rd, input logic [3:0] a0,
                        input logic [3:0] a1, input logic [3:0] a2);
        logic [9:0] nm [10];
        logic [9:0] nb;
        logic [3:0] a [3];
        logic       err;
        exp_t       e;
        @(negedge clk);
        write = wr; inaddr = wa; indata = wd;
        reserve = rs; resaddr = ra;
        read = rd; outaddr = {a2, a1, a0};
        a[0] = a0; a[1] = a1; a[2] = a2;
        for (int k = 0; k < 10; k++) nm[k] = m[k];
        nb  = bz;
        err = (wr && wa >= 10) || (rs && ra >= 10);
        if (wr && wa < 10) begin
            nm[wa] = wd;
            nb[wa] = 1'b0;
        end
        if (rs && ra < 10) nb[ra] = 1'b1;
        for (int p = 0; p < 3; p++) begin
            if (rd[p]) begin
                e.port = 2'(p);
                if (a[p] < 10) begin
                    e.d = nm[a[p]];
                    e.b = nb[a[p]];
                end else begin
                    e.d = '0;
                    e.b = 1'b0;
                    err = 1'b1;
                end
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) m[k] = nm[k];
        bz = nb;
        chk("outvalid", 32'(outvalid), 32'(rd));
        chk("addr_err", 32'(addr_err), 32'(err));
        chk("busy", 32'(busy), 32'(bz));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            last_d[e.port] = e.d;
            last_b[e.port] = e.b;
        end
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("outdata%0d", p), 32'(outdata[p*10 +: 10]), 32'(last_d[p]));
            chk($sformatf("outbusy%0d", p), 32'(outbusy[p]), 32'(last_b[p]));
        end
    endtask

    initial begin
        rst = 1'b0;
        write = 0; inaddr = 0; indata = 0; reserve = 0; resaddr = 0;
        read = 0; outaddr = 0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("rst_outdata", 32'(outdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outvalid", 32'(outvalid), 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);

        // basic writes then a three-port read
        step(1, 4'd0, 10'd1, 0, 0, 3'b000, 0, 0, 0);
        step(1, 4'd3, 10'd5, 0, 0, 3'b000, 0, 0, 0);
        step(1, 4'd6, 10'd7, 0, 0, 3'b000, 0, 0, 0);
        step(0, 0, 0, 0, 0, 3'b111, 4'd0, 4'd3, 4'd6);
        chk("triple_read", 32'(outdata), 32'({10'd7, 10'd5, 10'd1}));

        // write-to-read bypass on port1
        step(1, 4'd4, 10'h2AA, 0, 0, 3'b010, 0, 4'd4, 0);
        chk("bypass", 32'(outdata[19:10]), 32'h2AA);

        // scoreboard: reserve, read busy, writeback clears, reserve+write keeps busy
        step(0, 0, 0, 1, 4'd2, 3'b000, 0, 0, 0);
        step(0, 0, 0, 0, 0, 3'b001, 4'd2, 0, 0);
        chk("busy_read", 32'(outbusy[0]), 32'd1);
        step(1, 4'd2, 10'd9, 0, 0, 3'b001, 4'd2, 0, 0);
        chk("wb_data", 32'(outdata[9:0]), 32'd9);
        chk("wb_busy", 32'(busy[2]), 32'd0);
        step(1, 4'd5, 10'd3, 1, 4'd5, 3'b100, 0, 0, 4'd5);
        chk("res_wins", 32'(busy[5]), 32'd1);

        // out-of-range write and read; error pulse lasts one cycle
        step(1, 4'd12, 10'h3FF, 1, 4'd14, 3'b001, 4'd15, 0, 0);
        chk("oor_data", 32'(outdata[9:0]), 32'd0);
        step(0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
        chk("err_pulse_end", 32'(addr_err), 32'd0);

        // same address on all ports; then idle hold
        step(0, 0, 0, 0, 0, 3'b111, 4'd3, 4'd3, 4'd3);
        step(0, 0, 0, 0, 0, 3'b000, 4'd9, 4'd9, 4'd9);

        // randomised traffic across in-range and out-of-range addresses
        for (int n = 0; n < 60; n++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 10'($urandom),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        for (int k = 0; k < 10; k += 3)
            step(0, 0, 0, 0, 0, 3'b111, 4'(k), 4'(k + 1), 4'(k + 2));

        // reset during an active read
        step(1, 4'd1, 10'd33, 0, 0, 3'b111, 4'd0, 4'd1, 4'd3);
        #1;
        rst = 1'b0;
        #1;
        chk("async_valid", 32'(outvalid), 32'd0);
        chk("async_data", 32'(outdata), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        write = 0; reserve = 0; read = 0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 10; k += 3)
            step(0, 0, 0, 0, 0, 3'b111, 4'(k), 4'(k + 1), 4'(k + 2));
        chk("post_rst_r1", 32'(outdata[9:0] | outdata[19:10] | outdata[29:20]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/gpr_mp.md
Name: gpr_mp

Overview:
- Parametrised successor of the fixed 10x10-bit, 3-read general-purpose register file.
- Sits between decode/issue and the execute units; serves NRD read ports and one write port.
- Adds registered reads with valid strobes, write-to-read bypass, a per-register busy scoreboard (reserve at issue, clear on writeback) and address-range checking.

Parameters:
- WIDTH, 10, data bits per register.
- DEPTH, 10, number of registers (2..64).
- NRD, 3, number of read ports (1..8).
- AW, $clog2(DEPTH), address width (derived localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- write  in  1  write enable.
- inaddr  in  AW  write address.
- indata  in  WIDTH  write data.
- reserve  in  1  mark register busy (issue of an instruction targeting it).
- resaddr  in  AW  register to reserve.
- read  in  NRD  per-port read enable.
- outaddr  in  NRD*AW  per-port read address; port i at [i*AW +: AW].
- outdata  out  NRD*WIDTH  per-port read data, registered.
- outvalid  out  NRD  per-port one-cycle strobe: outdata is new.
- outbusy  out  NRD  per-port: the register read was busy at sample time.
- busy  out  DEPTH  scoreboard vector.
- addr_err  out  1  one-cycle pulse on any out-of-range access.

Behaviour:
- Reset (rst=0, asynchronous): all registers, outdata, outvalid, outbusy, busy and addr_err are 0. Release is synchronous to clk.
- Write: at posedge, if write and inaddr<DEPTH, then mem[inaddr]<=indata and busy[inaddr]<=0.
- Reserve: at posedge, if reserve and resaddr<DEPTH, then busy[resaddr]<=1.
- Write and reserve to the same address in the same cycle: data is written and busy ends at 1 (the new producer wins).
- Read, 1-cycle latency. If read[i] is high at posedge N, then after posedge N:
  - outvalid[i]=1.
  - outdata[i] = mem[outaddr[i]] as updated by posedge N. Write-first bypass applies: if write with inaddr==outaddr[i] in cycle N, outdata[i]=indata.
  - outbusy[i] = busy after the cycle-N update. A same-cycle write clears it unless a same-address reserve also occurs.
- If read[i] is low: outvalid[i]=0 and outdata[i]/outbusy[i] hold their last value.
- Multiple ports may read the same address in the same cycle; all return identical data.
- Out-of-range (address >= DEPTH):
  - Write or reserve is ignored.
  - Read returns outdata[i]=0, outvalid[i]=1, outbusy[i]=0.
  - addr_err=1 for one cycle after any such access (logical OR across all ports).
- No state machine beyond the storage and scoreboard. All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-read: outvalid drops to 0 immediately (asynchronous); the pending read is discarded.

Optional Feature:
- Macro: GPR_MP_DBG_EN.
- Defined: adds output dbg_regs (DEPTH*WIDTH, register k at [k*WIDTH +: WIDTH]). It is a live flattened copy of every register for simulation and board debug, replacing the old D_REGn outputs. It is 0 during reset.
- Undefined: the port is absent and no extra logic is generated.

Decomposition:
- Package gpr_pkg: default constants GPR_WIDTH=10, GPR_DEPTH=10, GPR_NRD=3, and the address/data typedefs.
- One sub-module, gpr_rdport: a single registered read port with the bypass mux and range check. It is instantiated NRD times via generate.
- The storage array and the scoreboard stay in gpr_mp.

Test Plan (WIDTH=10, DEPTH=10, NRD=3):
- Hold rst=0 for 2 cycles, then release -> all outdata=0, busy=0, outvalid=0, addr_err=0.
- Write r0=1, r3=5, r6=7 on consecutive cycles; then read port0 r0, port1 r3, port2 r6 in one cycle -> next cycle outdata={7,5,1} (port2..port0), outvalid=3'b111.
- Write r4=0x2AA and read r4 on port1 in the same cycle -> next cycle outdata[1]=0x2AA with outvalid[1]=1 (bypass).
- Reserve r2, then read r2 -> outbusy=1. Write r2=9 with a same-cycle read -> outdata=9, outbusy=0, busy[2]=0. Reserve plus write r5 in the same cycle -> busy[5]=1.
- Write addr 12 and read addr 15 on port0 -> no register changes; outdata[0]=0, outvalid[0]=1; addr_err pulses for 1 cycle.
- Assert rst during an active read -> outvalid drops to 0 asynchronously; after release all registers read 0.
